// File: rtl/shake_arbiter.sv
// Round-robin owner arbitration for the shared SHAKE core.
// One requester owns the core for a whole job. The core is cleared for one
// cycle between jobs so that no Keccak state carries over to the next owner.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | no owner, core held; arbitrate among req from rr_ptr upward
//   ST_BUSY  | owner's controls muxed to core, core status routed to owner
//   ST_FLUSH | one-cycle core clear after the owner's rel, no grant
module shake_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 64,
  parameter int IW    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      rel,
  output logic [N_REQ-1:0]      gnt,
  output logic [IW-1:0]         owner,
  input  logic [N_REQ-1:0]      rq_in_ready,
  input  logic [N_REQ-1:0]      rq_is_last,
  input  logic [N_REQ-1:0]      rq_squeeze,
  input  logic [N_REQ-1:0]      rq_mode,
  input  logic [2*N_REQ-1:0]    rq_byte_num,
  input  logic [DW*N_REQ-1:0]   rq_data,
  output logic                  sha_in_ready,
  output logic                  sha_is_last,
  output logic                  sha_squeeze,
  output logic                  sha_mode,
  output logic [1:0]            sha_byte_num,
  output logic [DW-1:0]         sha_data,
  output logic                  sha_hold,
  output logic                  sha_clear,
  input  logic                  sha_out_ready,
  output logic [N_REQ-1:0]      rq_out_ready
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_FLUSH
  } state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;

  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [IW:0]      cand;

  // Circular search from rr_ptr; scanning downward lets the nearest hit win.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(N_REQ)) begin
        cand = cand - (IW+1)'(N_REQ);
      end
      if (req[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  // Next-state, grant and round-robin pointer update.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d          = ST_BUSY;
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          owner_d          = win_idx;
        end
      end
      ST_BUSY: begin
        // Only the owner's rel ends the job; dropping req does not.
        if (rel[owner_q]) begin
          state_d  = ST_FLUSH;
          gnt_d    = '0;
          rr_ptr_d = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Registered arbitration state; reset aborts any job without a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Core-side mux from the owner and status return to the owner only.
  always_comb begin
    sha_in_ready = 1'b0;
    sha_is_last  = 1'b0;
    sha_squeeze  = 1'b0;
    sha_mode     = 1'b0;
    sha_byte_num = '0;
    sha_data     = '0;
    sha_hold     = 1'b1;
    sha_clear    = (state_q == ST_FLUSH);
    rq_out_ready = '0;
    if (state_q == ST_BUSY) begin
      sha_hold = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
        if (owner_q == IW'(k)) begin
          sha_in_ready    = rq_in_ready[k];
          sha_is_last     = rq_is_last[k];
          sha_squeeze     = rq_squeeze[k];
          sha_mode        = rq_mode[k];
          sha_byte_num    = rq_byte_num[2*k +: 2];
          sha_data        = rq_data[DW*k +: DW];
          rq_out_ready[k] = sha_out_ready;
        end
      end
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_shake_arbiter.sv
// Bench for shake_arbiter: directed scenarios with literal expectations plus
// a randomized run compared every cycle against a job-level model.
module tb_shake_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req, rel, gnt;
  logic [IW-1:0]     owner;
  logic [N-1:0]      rq_in_ready, rq_is_last, rq_squeeze, rq_mode;
  logic [2*N-1:0]    rq_byte_num;
  logic [DW*N-1:0]   rq_data;
  logic              sha_in_ready, sha_is_last, sha_squeeze, sha_mode;
  logic [1:0]        sha_byte_num;
  logic [DW-1:0]     sha_data;
  logic              sha_hold, sha_clear, sha_out_ready;
  logic [N-1:0]      rq_out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  shake_arbiter #(.N_REQ(N), .DW(DW), .IW(IW)) dut (
    .clk(clk), .reset(reset), .req(req), .rel(rel), .gnt(gnt), .owner(owner),
    .rq_in_ready(rq_in_ready), .rq_is_last(rq_is_last), .rq_squeeze(rq_squeeze),
    .rq_mode(rq_mode), .rq_byte_num(rq_byte_num), .rq_data(rq_data),
    .sha_in_ready(sha_in_ready), .sha_is_last(sha_is_last), .sha_squeeze(sha_squeeze),
    .sha_mode(sha_mode), .sha_byte_num(sha_byte_num), .sha_data(sha_data),
    .sha_hold(sha_hold), .sha_clear(sha_clear), .sha_out_ready(sha_out_ready),
    .rq_out_ready(rq_out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Job-level model: who owns the core, whether a clear cycle is pending,
  // and where the next circular search starts.
  bit m_busy  = 1'b0;
  bit m_flush = 1'b0;
  int m_owner = 0;
  int m_rr    = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0; m_flush = 1'b0; m_owner = 0; m_rr = 0;
    end else if (m_busy) begin
      if (rel[m_owner]) begin
        m_busy = 1'b0; m_flush = 1'b1; m_rr = (m_owner + 1) % N;
      end
    end else if (m_flush) begin
      m_flush = 1'b0;
    end else if (req != '0) begin
      for (int i = 0; i < N; i++) begin
        if (!m_busy && req[(m_rr + i) % N]) begin
          m_owner = (m_rr + i) % N;
          m_busy  = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison, just before the sampling edge.
  always @(negedge clk) begin
    logic [N-1:0] e_gnt, e_ror;
    #4;
    e_gnt = '0;
    e_ror = '0;
    if (m_busy) begin
      e_gnt[m_owner] = 1'b1;
      e_ror[m_owner] = sha_out_ready;
    end
    chk("gnt", gnt, e_gnt);
    if (m_busy) chk("owner", owner, m_owner);
    chk("sha_in_ready", sha_in_ready, m_busy ? rq_in_ready[m_owner] : 1'b0);
    chk("sha_is_last",  sha_is_last,  m_busy ? rq_is_last[m_owner]  : 1'b0);
    chk("sha_squeeze",  sha_squeeze,  m_busy ? rq_squeeze[m_owner]  : 1'b0);
    chk("sha_mode",     sha_mode,     m_busy ? rq_mode[m_owner]     : 1'b0);
    chk("sha_byte_num", sha_byte_num, m_busy ? rq_byte_num[2*m_owner +: 2] : 2'b0);
    chk("sha_data",     sha_data,     m_busy ? rq_data[DW*m_owner +: DW] : 64'h0);
    chk("sha_hold",     sha_hold,     !m_busy);
    chk("sha_clear",    sha_clear,    m_flush);
    chk("rq_out_ready", rq_out_ready, e_ror);
    chk("gnt_onehot0",  $onehot0(gnt), 1'b1);
    chk("ror_onehot0",  $onehot0(rq_out_ready), 1'b1);
  end

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic clear_inputs();
    req = '0; rel = '0; rq_in_ready = '0; rq_is_last = '0; rq_squeeze = '0;
    rq_mode = '0; rq_byte_num = '0; rq_data = '0; sha_out_ready = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    clear_inputs();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int seq[5];
    int exp_seq[5];
    int n;
    bit timed_out;
    exp_seq = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    // Reset state
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_owner", owner, 2'd0);
    chk("rst_hold", sha_hold, 1'b1);
    chk("rst_clear", sha_clear, 1'b0);
    chk("rst_ror", rq_out_ready, 4'b0000);
    reset = 1'b0;

    // Single requester
    req = 4'b0100;
    tick();
    chk("single_gnt", gnt, 4'b0100);
    chk("single_owner", owner, 2'd2);
    rq_data[2*DW +: DW] = 64'hA5A5;
    req = '0;
    #1;
    chk("single_data", sha_data, 64'hA5A5);
    rel = 4'b0100;
    tick();
    rel = '0;
    chk("single_flush_clear", sha_clear, 1'b1);
    chk("single_flush_gnt", gnt, 4'b0000);
    tick();
    chk("single_idle_clear", sha_clear, 1'b0);
    chk("single_idle_hold", sha_hold, 1'b1);

    // Round-robin with all requesting, 3 busy cycles per job
    do_reset();
    req = 4'hF;
    timed_out = 1'b0;
    for (int j = 0; j < 5 && !timed_out; j++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (gnt == '0 && n < 12);
      if (gnt == '0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rr_grant_timeout actual=none required=grant j=%0d", j);
        timed_out = 1'b1;
      end else begin
        seq[j] = int'(owner);
        chk("rr_order", seq[j], exp_seq[j]);
        chk("rr_gap", n, (j == 0) ? 1 : 2);
        tick();
        tick();
        rel = '0;
        rel[owner] = 1'b1;
        tick();
        rel = '0;
      end
    end

    // Isolation: non-owner rel/in_ready ignored, out_ready to owner only
    do_reset();
    req = 4'b0010;
    tick();
    chk("iso_gnt", gnt, 4'b0010);
    req = 4'hF; sha_out_ready = 1'b1; rel = 4'b1000; rq_in_ready = 4'b1000;
    #1;
    chk("iso_ror", rq_out_ready, 4'b0010);
    chk("iso_in_ready_other", sha_in_ready, 1'b0);
    tick();
    chk("iso_still_busy", gnt, 4'b0010);
    rq_in_ready = 4'b0010;
    #1;
    chk("iso_in_ready_owner", sha_in_ready, 1'b1);
    rel = 4'b0010;
    tick();
    chk("iso_rel_with_outready", sha_clear, 1'b1);
    clear_inputs();
    tick();

    // Release with new requests pending: rr_ptr skips requester 0
    do_reset();
    req = 4'b0001;
    tick();
    chk("sim_gnt0", gnt, 4'b0001);
    rel = 4'b0001; req = 4'b0011;
    tick();
    rel = '0;
    chk("sim_flush_gnt", gnt, 4'b0000);
    chk("sim_flush_clear", sha_clear, 1'b1);
    tick();
    chk("sim_idle_gnt", gnt, 4'b0000);
    tick();
    chk("sim_regrant", gnt, 4'b0010);
    rel = 4'b0010; req = '0;
    tick();
    rel = '0;
    tick();

    // Wrap-around from owner 3
    do_reset();
    req = 4'b1000;
    tick();
    chk("wrap_owner", owner, 2'd3);
    rel = 4'b1000; req = 4'b1001;
    tick();
    rel = '0;
    tick();
    tick();
    chk("wrap_gnt", gnt, 4'b0001);
    rel = 4'b0001; req = '0;
    tick();
    rel = '0;
    tick();

    // Reset mid-job
    do_reset();
    req = 4'b0100;
    tick();
    chk("midrst_busy", gnt, 4'b0100);
    reset = 1'b1;
    tick();
    chk("midrst_gnt", gnt, 4'b0000);
    chk("midrst_hold", sha_hold, 1'b1);
    chk("midrst_clear", sha_clear, 1'b0);
    reset = 1'b0; req = 4'b0110;
    tick();
    chk("midrst_regrant", gnt, 4'b0010);
    rel = 4'b0010; req = '0;
    tick();
    rel = '0;
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset         = ($urandom_range(0, 199) == 0);
      req           = N'($urandom);
      rel           = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      rq_in_ready   = N'($urandom);
      rq_is_last    = N'($urandom);
      rq_squeeze    = N'($urandom);
      rq_mode       = N'($urandom);
      rq_byte_num   = (2*N)'($urandom);
      sha_out_ready = 1'($urandom);
      for (int w = 0; w < (DW*N)/32; w++) rq_data[32*w +: 32] = $urandom;
    end
    tick();
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
